// File: rtl/instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// instr_fetch_unit
//   Fetch sequencer for the program ROM. It owns the program counter, drives the
//   ROM address, waits out the ROM access time and buffers fetched instructions
//   in a small prefetch FIFO that feeds the decoder.
//
// Optional feature macro: IFU_WRAP_HALT_EN
//   defined     : capturing address 2^AW-1 sets the sticky wrap_halt flag and
//                 parks the unit in HALTED until a redirect (pc still wraps to 0).
//   not defined : pc wraps silently to 0 and wrap_halt is tied low.
//
// Ports
//   clk          in   rising-edge clock
//   rst          in   asynchronous reset, active-high
//   rom_addr     out  ROM address (registered, always equal to the pc)
//   rom_data     in   ROM read data
//   ir_valid     out  FIFO head holds an instruction
//   ir_data      out  instruction at the FIFO head
//   ir_pc        out  address the head instruction was fetched from
//   ir_ready     in   decoder accepts the head this cycle
//   redirect     in   one-cycle pulse: load pc from redirect_pc, flush the FIFO
//   redirect_pc  in   new pc
//   halt         in   level: suspend new captures (FIFO keeps draining)
//   wrap_halt    out  sticky pc-wrap flag
//   dbg_state    out  current FSM state (0 FETCH, 1 STALL, 2 HALTED)
//
// Handshake: an instruction moves to the decoder on every rising edge where
//   ir_valid && ir_ready are both high, unless redirect is high on that edge
//   (redirect flushes instead). ir_valid never drops without a pop or redirect,
//   and ir_data/ir_pc stay stable while ir_valid && !ir_ready.
// -----------------------------------------------------------------------------
module instr_fetch_unit #(
  parameter int AW          = 8,
  parameter int DW          = 16,
  parameter int WAIT_CYCLES = 1,
  parameter int DEPTH       = 2
) (
  input  logic          clk,
  input  logic          rst,
  output logic [AW-1:0] rom_addr,
  input  logic [DW-1:0] rom_data,
  output logic          ir_valid,
  output logic [DW-1:0] ir_data,
  output logic [AW-1:0] ir_pc,
  input  logic          ir_ready,
  input  logic          redirect,
  input  logic [AW-1:0] redirect_pc,
  input  logic          halt,
  output logic          wrap_halt,
  output logic [1:0]    dbg_state
);

  localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam int PW = $clog2(DEPTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WAIT_CYCLES - 1);

  localparam logic [1:0] S_FETCH  = 2'd0;
  localparam logic [1:0] S_STALL  = 2'd1;
  localparam logic [1:0] S_HALTED = 2'd2;

  logic [1:0]    r_state;
  logic [AW-1:0] r_pc;
  logic [CW-1:0] r_cnt;
  // Pointers carry one extra bit so full and empty are distinguishable.
  logic [PW:0]   r_wptr;
  logic [PW:0]   r_rptr;
  logic [DW-1:0] r_mem_data [DEPTH];
  logic [AW-1:0] r_mem_pc   [DEPTH];

  logic [1:0]    w_state_nxt;
  logic [AW-1:0] w_pc_nxt;
  logic [CW-1:0] w_cnt_nxt;
  logic          w_empty;
  logic          w_full;
  logic          w_pop;
  logic          w_space;
  logic          w_push;
  logic          w_wrap_hit;

  assign w_empty = (r_wptr == r_rptr);
  assign w_full  = (r_wptr[PW] != r_rptr[PW]) &&
                   (r_wptr[PW-1:0] == r_rptr[PW-1:0]);
  assign w_pop   = !w_empty && ir_ready && !redirect;
  // A pop on the same edge frees a slot, so a full FIFO can still accept.
  assign w_space = !w_full || w_pop;
  assign w_push  = !redirect && !halt && w_space &&
                   (((r_state == S_FETCH) && (r_cnt == CNT_LAST)) ||
                    (r_state == S_STALL));

`ifdef IFU_WRAP_HALT_EN
  logic r_wrap;
  assign w_wrap_hit = w_push && (r_pc == {AW{1'b1}});

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wrap <= 1'b0;
    end else if (redirect) begin
      r_wrap <= 1'b0;
    end else if (w_wrap_hit) begin
      r_wrap <= 1'b1;
    end
  end

  assign wrap_halt = r_wrap;
`else
  assign w_wrap_hit = 1'b0;
  assign wrap_halt  = 1'b0;
`endif

  // Next-state logic: redirect beats halt, halt beats capture.
  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_cnt_nxt   = r_cnt;
    if (redirect) begin
      w_state_nxt = halt ? S_HALTED : S_FETCH;
      w_pc_nxt    = redirect_pc;
      w_cnt_nxt   = '0;
    end else if (halt) begin
      w_state_nxt = S_HALTED;
      w_cnt_nxt   = '0;
    end else begin
      case (r_state)
        S_FETCH: begin
          if (r_cnt == CNT_LAST) begin
            w_cnt_nxt = '0;
            if (w_space) begin
              w_pc_nxt = r_pc + AW'(1);
            end else begin
              w_state_nxt = S_STALL;
            end
          end else begin
            w_cnt_nxt = r_cnt + CW'(1);
          end
        end
        S_STALL: begin
          if (w_space) begin
            w_pc_nxt    = r_pc + AW'(1);
            w_state_nxt = S_FETCH;
            w_cnt_nxt   = '0;
          end
        end
        S_HALTED: begin
          // A wrap-induced halt is only left through redirect.
          if (!wrap_halt) begin
            w_state_nxt = S_FETCH;
            w_cnt_nxt   = '0;
          end
        end
        default: begin
          w_state_nxt = S_FETCH;
          w_cnt_nxt   = '0;
        end
      endcase
      if (w_wrap_hit) begin
        w_state_nxt = S_HALTED;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_FETCH;
      r_pc    <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Prefetch FIFO. Flush simply moves the read pointer onto the write pointer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem_data[i] <= '0;
        r_mem_pc[i]   <= '0;
      end
    end else if (redirect) begin
      r_rptr <= r_wptr;
    end else begin
      if (w_push) begin
        r_mem_data[r_wptr[PW-1:0]] <= rom_data;
        r_mem_pc[r_wptr[PW-1:0]]   <= r_pc;
        r_wptr                     <= r_wptr + (PW+1)'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + (PW+1)'(1);
      end
    end
  end

  assign rom_addr  = r_pc;
  assign ir_valid  = !w_empty;
  assign ir_data   = r_mem_data[r_rptr[PW-1:0]];
  assign ir_pc     = r_mem_pc[r_rptr[PW-1:0]];
  assign dbg_state = r_state;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_instr_fetch_unit
//   Directed, table-driven bench for instr_fetch_unit. Two instances share the
//   control inputs: u_dut1 (WAIT_CYCLES=1) and u_dut2 (WAIT_CYCLES=3); each is
//   held in reset while the other one is exercised. Each table row gives the
//   inputs applied before an edge and the outputs expected just after it.
// -----------------------------------------------------------------------------
module tb_instr_fetch_unit;

  localparam logic [1:0] ST_F = 2'd0;
  localparam logic [1:0] ST_S = 2'd1;
  localparam logic [1:0] ST_H = 2'd2;

  typedef struct packed {
    logic        rdy;
    logic        redir;
    logic [7:0]  rpc;
    logic        halt;
    logic        ev;
    logic [7:0]  epc;
    logic [15:0] edata;
    logic [7:0]  eaddr;
    logic        ewrap;
    logic [1:0]  est;
  } vec_t;

  // clock / reset
  logic clk = 1'b0;
  logic rst1 = 1'b1;
  logic rst2 = 1'b1;
  always #5 clk = ~clk;

  // shared control inputs
  logic       ir_ready    = 1'b0;
  logic       redirect    = 1'b0;
  logic [7:0] redirect_pc = 8'h00;
  logic       halt        = 1'b0;

  logic [7:0]  rom_addr1, ir_pc1, rom_addr2, ir_pc2;
  logic [15:0] rom_data1, ir_data1, rom_data2, ir_data2;
  logic        ir_valid1, wrap_halt1, ir_valid2, wrap_halt2;
  logic [1:0]  dbg_state1, dbg_state2;

  int checks   = 0;
  int failures = 0;

  function automatic logic [15:0] rom_f(input logic [7:0] a);
    case (a)
      8'h00:   rom_f = 16'h9DFF;
      8'h01:   rom_f = 16'h920A;
      8'h02:   rom_f = 16'hAF04;
      8'h08:   rom_f = 16'hE00F;
      default: rom_f = {8'h5A, a};
    endcase
  endfunction

  always_comb rom_data1 = rom_f(rom_addr1);
  always_comb rom_data2 = rom_f(rom_addr2);

  instr_fetch_unit #(.AW(8), .DW(16), .WAIT_CYCLES(1), .DEPTH(2)) u_dut1 (
    .clk(clk), .rst(rst1), .rom_addr(rom_addr1), .rom_data(rom_data1),
    .ir_valid(ir_valid1), .ir_data(ir_data1), .ir_pc(ir_pc1),
    .ir_ready(ir_ready), .redirect(redirect), .redirect_pc(redirect_pc),
    .halt(halt), .wrap_halt(wrap_halt1), .dbg_state(dbg_state1)
  );

  instr_fetch_unit #(.AW(8), .DW(16), .WAIT_CYCLES(3), .DEPTH(2)) u_dut2 (
    .clk(clk), .rst(rst2), .rom_addr(rom_addr2), .rom_data(rom_data2),
    .ir_valid(ir_valid2), .ir_data(ir_data2), .ir_pc(ir_pc2),
    .ir_ready(ir_ready), .redirect(redirect), .redirect_pc(redirect_pc),
    .halt(halt), .wrap_halt(wrap_halt2), .dbg_state(dbg_state2)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic rdy, input logic redir, input logic [7:0] rpc,
                              input logic hlt, input logic ev, input logic [7:0] epc,
                              input logic [15:0] edata, input logic [7:0] eaddr,
                              input logic ewrap, input logic [1:0] est);
    vec_t v;
    v.rdy = rdy; v.redir = redir; v.rpc = rpc; v.halt = hlt;
    v.ev = ev; v.epc = epc; v.edata = edata; v.eaddr = eaddr;
    v.ewrap = ewrap; v.est = est;
    return v;
  endfunction

  // Compare every output of the selected instance against all-zero reset values.
  task automatic chk_zero(input string tag, input int sel);
    if (sel == 1) begin
      chk({tag, ".addr"},  32'(rom_addr1),  32'h0);
      chk({tag, ".valid"}, 32'(ir_valid1),  32'h0);
      chk({tag, ".data"},  32'(ir_data1),   32'h0);
      chk({tag, ".pc"},    32'(ir_pc1),     32'h0);
      chk({tag, ".wrap"},  32'(wrap_halt1), 32'h0);
      chk({tag, ".state"}, 32'(dbg_state1), 32'(ST_F));
    end else begin
      chk({tag, ".addr"},  32'(rom_addr2),  32'h0);
      chk({tag, ".valid"}, 32'(ir_valid2),  32'h0);
      chk({tag, ".data"},  32'(ir_data2),   32'h0);
      chk({tag, ".pc"},    32'(ir_pc2),     32'h0);
      chk({tag, ".wrap"},  32'(wrap_halt2), 32'h0);
      chk({tag, ".state"}, 32'(dbg_state2), 32'(ST_F));
    end
  endtask

  // driver: called at a negedge, applies one row, checks just after the posedge
  task automatic step(input string tag, input int sel, input vec_t v);
    logic [7:0]  a_addr, a_pc;
    logic [15:0] a_data;
    logic        a_valid, a_wrap;
    logic [1:0]  a_st;
    ir_ready    = v.rdy;
    redirect    = v.redir;
    redirect_pc = v.rpc;
    halt        = v.halt;
    @(posedge clk);
    #1;
    if (sel == 1) begin
      a_addr = rom_addr1; a_pc = ir_pc1; a_data = ir_data1;
      a_valid = ir_valid1; a_wrap = wrap_halt1; a_st = dbg_state1;
    end else begin
      a_addr = rom_addr2; a_pc = ir_pc2; a_data = ir_data2;
      a_valid = ir_valid2; a_wrap = wrap_halt2; a_st = dbg_state2;
    end
    chk({tag, ".valid"}, 32'(a_valid), 32'(v.ev));
    chk({tag, ".addr"},  32'(a_addr),  32'(v.eaddr));
    chk({tag, ".wrap"},  32'(a_wrap),  32'(v.ewrap));
    chk({tag, ".state"}, 32'(a_st),    32'(v.est));
    if (v.ev) begin
      chk({tag, ".pc"},   32'(a_pc),   32'(v.epc));
      chk({tag, ".data"}, 32'(a_data), 32'(v.edata));
    end
    @(negedge clk);
  endtask

  vec_t va[$];
  vec_t vb[$];

  initial begin
    // ---- WAIT_CYCLES=1 table ----
    //             rdy  rd   rpc    hlt  ev   epc    edata     eaddr  wrap  st
    va.push_back(mk(1, 0, 8'h00, 0, 1, 8'h00, 16'h9DFF, 8'h01, 0, ST_F)); // first fetch
    va.push_back(mk(1, 0, 8'h00, 0, 1, 8'h01, 16'h920A, 8'h02, 0, ST_F));
    va.push_back(mk(1, 0, 8'h00, 0, 1, 8'h02, 16'hAF04, 8'h03, 0, ST_F));
    va.push_back(mk(0, 1, 8'h00, 0, 0, 8'h00, 16'h0000, 8'h00, 0, ST_F)); // restart at 0
    va.push_back(mk(0, 0, 8'h00, 0, 1, 8'h00, 16'h9DFF, 8'h01, 0, ST_F)); // fill
    va.push_back(mk(0, 0, 8'h00, 0, 1, 8'h00, 16'h9DFF, 8'h02, 0, ST_F)); // full
    va.push_back(mk(0, 0, 8'h00, 0, 1, 8'h00, 16'h9DFF, 8'h02, 0, ST_S)); // stall
    va.push_back(mk(0, 0, 8'h00, 0, 1, 8'h00, 16'h9DFF, 8'h02, 0, ST_S));
    va.push_back(mk(1, 0, 8'h00, 0, 1, 8'h01, 16'h920A, 8'h03, 0, ST_F)); // drain
    va.push_back(mk(1, 0, 8'h00, 0, 1, 8'h02, 16'hAF04, 8'h04, 0, ST_F));
    va.push_back(mk(1, 1, 8'h08, 0, 0, 8'h00, 16'h0000, 8'h08, 0, ST_F)); // redirect full
    va.push_back(mk(1, 0, 8'h00, 0, 1, 8'h08, 16'hE00F, 8'h09, 0, ST_F));
    va.push_back(mk(0, 0, 8'h00, 0, 1, 8'h08, 16'hE00F, 8'h0A, 0, ST_F));
    va.push_back(mk(0, 0, 8'h00, 1, 1, 8'h08, 16'hE00F, 8'h0A, 0, ST_H)); // halt x4
    va.push_back(mk(1, 0, 8'h00, 1, 1, 8'h09, 16'h5A09, 8'h0A, 0, ST_H));
    va.push_back(mk(1, 0, 8'h00, 1, 0, 8'h00, 16'h0000, 8'h0A, 0, ST_H));
    va.push_back(mk(1, 0, 8'h00, 1, 0, 8'h00, 16'h0000, 8'h0A, 0, ST_H));
    va.push_back(mk(1, 0, 8'h00, 0, 0, 8'h00, 16'h0000, 8'h0A, 0, ST_F)); // re-wait
    va.push_back(mk(1, 0, 8'h00, 0, 1, 8'h0A, 16'h5A0A, 8'h0B, 0, ST_F)); // same pc
    va.push_back(mk(1, 1, 8'hFE, 0, 0, 8'h00, 16'h0000, 8'hFE, 0, ST_F)); // wrap test
    va.push_back(mk(1, 0, 8'h00, 0, 1, 8'hFE, 16'h5AFE, 8'hFF, 0, ST_F));
`ifdef IFU_WRAP_HALT_EN
    va.push_back(mk(1, 0, 8'h00, 0, 1, 8'hFF, 16'h5AFF, 8'h00, 1, ST_H));
    va.push_back(mk(1, 0, 8'h00, 0, 0, 8'h00, 16'h0000, 8'h00, 1, ST_H));
    va.push_back(mk(1, 0, 8'h00, 0, 0, 8'h00, 16'h0000, 8'h00, 1, ST_H));
`else
    va.push_back(mk(1, 0, 8'h00, 0, 1, 8'hFF, 16'h5AFF, 8'h00, 0, ST_F));
    va.push_back(mk(1, 0, 8'h00, 0, 1, 8'h00, 16'h9DFF, 8'h01, 0, ST_F));
    va.push_back(mk(1, 0, 8'h00, 0, 1, 8'h01, 16'h920A, 8'h02, 0, ST_F));
`endif
    va.push_back(mk(1, 1, 8'h01, 0, 0, 8'h00, 16'h0000, 8'h01, 0, ST_F)); // resume
    va.push_back(mk(1, 0, 8'h00, 0, 1, 8'h01, 16'h920A, 8'h02, 0, ST_F));

    // ---- WAIT_CYCLES=3 table ----
    vb.push_back(mk(0, 0, 8'h00, 0, 0, 8'h00, 16'h0000, 8'h00, 0, ST_F));
    vb.push_back(mk(0, 0, 8'h00, 0, 0, 8'h00, 16'h0000, 8'h00, 0, ST_F));
    vb.push_back(mk(0, 0, 8'h00, 0, 1, 8'h00, 16'h9DFF, 8'h01, 0, ST_F)); // 3rd edge
    vb.push_back(mk(0, 0, 8'h00, 0, 1, 8'h00, 16'h9DFF, 8'h01, 0, ST_F));
    vb.push_back(mk(0, 0, 8'h00, 0, 1, 8'h00, 16'h9DFF, 8'h01, 0, ST_F));
    vb.push_back(mk(0, 0, 8'h00, 0, 1, 8'h00, 16'h9DFF, 8'h02, 0, ST_F));
    vb.push_back(mk(0, 0, 8'h00, 0, 1, 8'h00, 16'h9DFF, 8'h02, 0, ST_F));
    vb.push_back(mk(0, 0, 8'h00, 0, 1, 8'h00, 16'h9DFF, 8'h02, 0, ST_F));
    vb.push_back(mk(0, 0, 8'h00, 0, 1, 8'h00, 16'h9DFF, 8'h02, 0, ST_S));
    vb.push_back(mk(1, 0, 8'h00, 0, 1, 8'h01, 16'h920A, 8'h03, 0, ST_F));
    vb.push_back(mk(1, 0, 8'h00, 0, 1, 8'h02, 16'hAF04, 8'h03, 0, ST_F));
    vb.push_back(mk(1, 0, 8'h00, 0, 0, 8'h00, 16'h0000, 8'h03, 0, ST_F));
    vb.push_back(mk(1, 0, 8'h00, 0, 1, 8'h03, 16'h5A03, 8'h04, 0, ST_F));

    // reset state with clock running
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_zero("reset1", 1);
    chk_zero("reset2", 2);

    // WAIT_CYCLES=1 run
    ir_ready = 1'b1;
    rst1 = 1'b0;
    foreach (va[i]) step($sformatf("A%0d", i), 1, va[i]);

    // WAIT_CYCLES=3 run
    rst1 = 1'b1;
    ir_ready = 1'b0;
    rst2 = 1'b0;
    foreach (vb[i]) step($sformatf("B%0d", i), 2, vb[i]);

    // async reset in the middle of a 3-cycle wait: outputs clear with no edge
    ir_ready = 1'b0;
    @(posedge clk);
    #2;
    rst2 = 1'b1;
    #1;
    chk_zero("async_rst", 2);
    @(negedge clk);
    rst2 = 1'b0;
    // aborted fetch must not leak: first valid only after a full fresh wait
    step("R0", 2, mk(0, 0, 8'h00, 0, 0, 8'h00, 16'h0000, 8'h00, 0, ST_F));
    step("R1", 2, mk(0, 0, 8'h00, 0, 0, 8'h00, 16'h0000, 8'h00, 0, ST_F));
    step("R2", 2, mk(0, 0, 8'h00, 0, 1, 8'h00, 16'h9DFF, 8'h01, 0, ST_F));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
